fxp_chan_accum: RTL

- Multi-channel signed fixed-point accumulator with saturating or wrapping output narrowing.
- Generalises the two-operand fixed-point adder with overflow/underflow flags: NUM_CH independent channels, wide guard-bit accumulation, a valid/ready handshake, and a registered output stage.
- Sits between sample producers (filter taps, MAC lanes) and downstream fixed-point consumers in the datapath.

---
 rtl/fxp_chan_accum.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fxp_chan_accum.sv
`default_nettype none
// ============================================================================
// Module   : fxp_chan_accum
// Brief    : NUM_CH-channel signed fixed-point accumulator with guard bits and
//            a registered, flagged, narrowing output stage.
//            Optional macro FXP_CHAN_ACCUM_SAT_EN selects saturating narrowing.
// Revision : 1.0
// ============================================================================
module fxp_chan_accum #(
    parameter  int DATA_WIDTH = 16,
    parameter  int FIXED_PNT  = 8,
    parameter  int NUM_CH     = 4,
    parameter  int GUARD_BITS = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_ovf,
    output logic                  out_unf
);

    localparam int ACC_W = DATA_WIDTH + GUARD_BITS;
    localparam int CNT_W = GUARD_BITS + 1;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'((1 << GUARD_BITS) - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    localparam logic signed [ACC_W-1:0] C_POS_MAX =
        {{(GUARD_BITS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_NEG_MIN =
        {{(GUARD_BITS + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Input and output share one Q format, so FIXED_PNT only needs to be sane.
    if (FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_fixed_pnt
        $error("fxp_chan_accum: FIXED_PNT must lie in [0, DATA_WIDTH)");
    end

    logic signed [ACC_W-1:0] r_acc [NUM_CH];
    logic        [CNT_W-1:0] r_cnt [NUM_CH];

    logic signed [ACC_W-1:0]      w_sel_acc;
    logic        [CNT_W-1:0]      w_sel_cnt;
    logic signed [ACC_W-1:0]      w_sum;
    logic                         w_ch_ok;
    logic                         w_accept;
    logic                         w_close;
    logic                         w_load;
    logic                         w_ovf;
    logic                         w_unf;
    logic        [DATA_WIDTH-1:0] w_narrow;

    assign in_ready = rst_n && !clr && (!out_valid || out_ready);
    assign w_ch_ok  = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
    assign w_accept = in_valid && in_ready && w_ch_ok;

    always_comb begin
        w_sel_acc = '0;
        w_sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                w_sel_acc = r_acc[i];
                w_sel_cnt = r_cnt[i];
            end
        end
    end

    assign w_sum   = w_sel_acc + {{GUARD_BITS{in_data[DATA_WIDTH-1]}}, in_data};
    assign w_close = in_last || (w_sel_cnt == C_CNT_MAX);
    assign w_load  = w_accept && w_close;
    assign w_ovf   = (w_sum > C_POS_MAX);
    assign w_unf   = (w_sum < C_NEG_MIN);

`ifdef FXP_CHAN_ACCUM_SAT_EN
    always_comb begin
        w_narrow = w_sum[DATA_WIDTH-1:0];
        if (w_ovf) begin
            w_narrow = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (w_unf) begin
            w_narrow = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end
    end
`else
    assign w_narrow = w_sum[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_ch == CH_W'(i)) begin
                    if (w_close) begin
                        r_acc[i] <= '0;
                        r_cnt[i] <= '0;
                    end else begin
                        r_acc[i] <= w_sum;
                        r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
                    end
                end
            end
        end
    end

    // A closing beat can only be accepted when the slot is free or draining,
    // so a load always wins over the handshake-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_sum   <= w_narrow;
            out_ovf   <= w_ovf;
            out_unf   <= w_unf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
